// File: rtl/prog_counter.sv
// prog_counter: bounded up/down counter with programmable limit and step,
// wrap or saturate at the bounds, a one-shot run mode (IDLE/RUN/DONE) and
// a compare-match output.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-high reset, clears all state
//   clear      synchronous clear of count, tc and state (state -> IDLE)
//   start      pulse, IDLE or DONE -> RUN
//   enable     advance qualifier, only acts in RUN
//   load       synchronous load of min(load_data, limit)
//   load_data  value to load
//   dir        0 = up, 1 = down
//   step       amount added/subtracted per advance
//   limit      inclusive upper bound of the count range 0..limit
//   sat        1 = saturate at the bound, 0 = wrap
//   oneshot    1 = go to DONE on the first terminal event
//   cmp_val    compare value for hit
//   count      registered count
//   tc         registered one-cycle terminal-count pulse
//   busy       state is RUN
//   done       state is DONE
//   hit        count == cmp_val, decoded straight from the count register
module prog_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             dir,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic             sat,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic             hit
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_nextCount;
  logic             r_tc;
  logic             w_nextTc;

  logic [WIDTH:0]   w_sum;
  logic             w_overLimit;
  logic             w_upTerm;
  logic             w_downTerm;
  logic [WIDTH-1:0] w_upTermVal;
  logic [WIDTH-1:0] w_downTermVal;
  logic [WIDTH-1:0] w_loadVal;

  // One extra bit on the sum so count+step can be compared against limit
  // without overflow hiding a terminal event.
  assign w_sum         = {1'b0, r_count} + {1'b0, step};
  assign w_overLimit   = (r_count > limit);
  assign w_upTerm      = (w_sum > {1'b0, limit});
  assign w_downTerm    = (r_count < step);
  assign w_upTermVal   = sat ? limit : '0;
  assign w_downTermVal = sat ? '0 : limit;
  assign w_loadVal     = (load_data > limit) ? limit : load_data;

  // State, count and tc registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
      r_tc    <= w_nextTc;
    end
  end

  // Next-state logic with priority clear > load > advance. A count that
  // sits above a freshly lowered limit is a terminal event in either
  // direction and is pulled to the up-direction terminal value.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_nextTc    = 1'b0;
    if (clear) begin
      w_nextState = IDLE;
      w_nextCount = '0;
    end else if (load) begin
      w_nextCount = w_loadVal;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            w_nextState = RUN;
          end
        end
        RUN: begin
          if (enable) begin
            if (w_overLimit) begin
              w_nextTc    = 1'b1;
              w_nextCount = w_upTermVal;
            end else if (!dir) begin
              if (w_upTerm) begin
                w_nextTc    = 1'b1;
                w_nextCount = w_upTermVal;
              end else begin
                w_nextCount = w_sum[WIDTH-1:0];
              end
            end else begin
              if (w_downTerm) begin
                w_nextTc    = 1'b1;
                w_nextCount = w_downTermVal;
              end else begin
                w_nextCount = r_count - step;
              end
            end
            if (w_nextTc && oneshot) begin
              w_nextState = DONE;
            end
          end
        end
        default: begin
          w_nextState = IDLE;
        end
      endcase
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign busy  = (r_state == RUN);
  assign done  = (r_state == DONE);
  assign hit   = (r_count == cmp_val);

endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: directed scenarios plus a randomized run for
// prog_counter, compared against an arithmetic reference model.
module tb_prog_counter;

  localparam int WIDTH = 8;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic             clk;
  logic             reset;
  logic             clear;
  logic             start;
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             dir;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] limit;
  logic             sat;
  logic             oneshot;
  logic [WIDTH-1:0] cmp_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;
  logic             hit;

  int checks = 0;
  int errors = 0;

  int mCount;
  int mTc;
  int mState;

  prog_counter #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .start(start),
    .enable(enable),
    .load(load),
    .load_data(load_data),
    .dir(dir),
    .step(step),
    .limit(limit),
    .sat(sat),
    .oneshot(oneshot),
    .cmp_val(cmp_val),
    .count(count),
    .tc(tc),
    .busy(busy),
    .done(done),
    .hit(hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of one clock edge, written from the counting rules
  // with plain integer arithmetic.
  function automatic void modelEdge();
    int lim;
    int c;
    int s;
    int nxt;
    int term;
    lim  = int'(limit);
    c    = mCount;
    s    = int'(step);
    mTc  = 0;
    if (clear) begin
      mCount = 0;
      mState = M_IDLE;
    end else if (load) begin
      mCount = (int'(load_data) < lim) ? int'(load_data) : lim;
    end else if (mState == M_RUN) begin
      if (enable) begin
        term = 0;
        nxt  = c;
        if (c > lim) begin
          term = 1;
          nxt  = sat ? lim : 0;
        end else if (!dir) begin
          if (c + s > lim) begin
            term = 1;
            nxt  = sat ? lim : 0;
          end else begin
            nxt = c + s;
          end
        end else begin
          if (c < s) begin
            term = 1;
            nxt  = sat ? 0 : lim;
          end else begin
            nxt = c - s;
          end
        end
        mCount = nxt;
        mTc    = term;
        if (term == 1 && oneshot) mState = M_DONE;
      end
    end else if (start) begin
      mState = M_RUN;
    end
  endfunction

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic applyQuiet();
    clear  = 1'b0;
    start  = 1'b0;
    enable = 1'b0;
    load   = 1'b0;
  endtask

  task automatic test_reset();
    applyQuiet();
    load_data = '0;
    dir       = 1'b0;
    step      = 8'd1;
    limit     = 8'd9;
    sat       = 1'b0;
    oneshot   = 1'b0;
    cmp_val   = '0;
    reset     = 1'b1;
    mCount = 0; mTc = 0; mState = M_IDLE;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (count !== 8'd0) begin errors++; $display("[TB] FAIL reset_count got %0d expected 0", count); end
    checks++;
    if (tc !== 1'b0) begin errors++; $display("[TB] FAIL reset_tc got %0b expected 0", tc); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL reset_state got busy=%0b done=%0b expected 0 0", busy, done); end
    checks++;
    if (hit !== 1'b1) begin errors++; $display("[TB] FAIL reset_hit got %0b expected 1", hit); end
  endtask

  // Up-count with wrap at limit 9.
  task automatic test_wrap_up();
    int expC;
    applyQuiet();
    limit = 8'd9; step = 8'd1; dir = 1'b0; sat = 1'b0; oneshot = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL wrap_start_busy got %0b expected 1", busy); end
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      expC = (i + 1) % 10;
      checks++;
      if (count !== expC[WIDTH-1:0]) begin errors++; $display("[TB] FAIL wrap_count[%0d] got %0d expected %0d", i, count, expC); end
      checks++;
      if (tc !== (i == 9)) begin errors++; $display("[TB] FAIL wrap_tc[%0d] got %0b expected %0b", i, tc, (i == 9)); end
    end
    enable = 1'b0;
  endtask

  // Down-count with saturation at zero.
  task automatic test_sat_down();
    int expC[4];
    int expT[4];
    expC = '{6, 2, 0, 0};
    expT = '{0, 0, 1, 1};
    applyQuiet();
    limit = 8'd10; step = 8'd4; dir = 1'b1; sat = 1'b1;
    load = 1'b1; load_data = 8'd10;
    tick();
    load = 1'b0;
    checks++;
    if (count !== 8'd10) begin errors++; $display("[TB] FAIL satdown_load got %0d expected 10", count); end
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (count !== expC[i][WIDTH-1:0]) begin errors++; $display("[TB] FAIL satdown_count[%0d] got %0d expected %0d", i, count, expC[i]); end
      checks++;
      if (tc !== expT[i][0]) begin errors++; $display("[TB] FAIL satdown_tc[%0d] got %0b expected %0d", i, tc, expT[i]); end
    end
    enable = 1'b0;
  endtask

  // One-shot run ending in DONE, then restart.
  task automatic test_oneshot();
    applyQuiet();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    limit = 8'd3; step = 8'd1; dir = 1'b0; sat = 1'b0; oneshot = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (count !== ((i + 1) % 4)) begin errors++; $display("[TB] FAIL oneshot_count[%0d] got %0d expected %0d", i, count, (i + 1) % 4); end
      checks++;
      if (tc !== (i == 3)) begin errors++; $display("[TB] FAIL oneshot_tc[%0d] got %0b expected %0b", i, tc, (i == 3)); end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL oneshot_done got done=%0b busy=%0b expected 1 0", done, busy); end
    repeat (2) tick();
    checks++;
    if (count !== 8'd0 || tc !== 1'b0 || done !== 1'b1) begin errors++; $display("[TB] FAIL oneshot_hold got count=%0d tc=%0b done=%0b expected 0 0 1", count, tc, done); end
    enable = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || count !== 8'd0) begin errors++; $display("[TB] FAIL oneshot_restart got busy=%0b done=%0b count=%0d expected 1 0 0", busy, done, count); end
    oneshot = 1'b0;
  endtask

  // Load clamping, load blocks advance, clear beats load.
  task automatic test_load_clear();
    applyQuiet();
    limit = 8'd50; step = 8'd1; dir = 1'b0;
    load = 1'b1; load_data = 8'd200; enable = 1'b1;
    tick();
    checks++;
    if (count !== 8'd50 || tc !== 1'b0) begin errors++; $display("[TB] FAIL load_clamp got count=%0d tc=%0b expected 50 0", count, tc); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL load_state got busy=%0b expected 1", busy); end
    clear = 1'b1;
    tick();
    applyQuiet();
    checks++;
    if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || tc !== 1'b0) begin errors++; $display("[TB] FAIL clear_over_load got count=%0d busy=%0b done=%0b tc=%0b expected 0 0 0 0", count, busy, done, tc); end
  endtask

  // Compare-match follows count.
  task automatic test_hit();
    applyQuiet();
    cmp_val = 8'd5; limit = 8'd20; step = 8'd1; dir = 1'b0; sat = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (hit !== (i + 1 == 5)) begin errors++; $display("[TB] FAIL hit[%0d] got %0b expected %0b (count=%0d)", i, hit, (i + 1 == 5), count); end
    end
    applyQuiet();
  endtask

  // Asynchronous reset in the middle of a run.
  task automatic test_async_reset();
    applyQuiet();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    limit = 8'd20; step = 8'd1; dir = 1'b0; cmp_val = 8'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    enable = 1'b1;
    repeat (7) tick();
    checks++;
    if (count !== 8'd7 || busy !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre got count=%0d busy=%0b expected 7 1", count, busy); end
    #2;
    reset = 1'b1;
    mCount = 0; mTc = 0; mState = M_IDLE;
    #1;
    checks++;
    if (count !== 8'd0 || busy !== 1'b0 || tc !== 1'b0) begin errors++; $display("[TB] FAIL arst_now got count=%0d busy=%0b tc=%0b expected 0 0 0", count, busy, tc); end
    #3;
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if (count !== 8'd0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL arst_after got count=%0d busy=%0b expected 0 0", count, busy); end
    applyQuiet();
  endtask

  // Randomized run against the model.
  task automatic test_random();
    applyQuiet();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 600; i++) begin
      clear  = ($urandom_range(0, 39) == 0);
      load   = ($urandom_range(0, 14) == 0);
      start  = ($urandom_range(0, 7) == 0);
      enable = ($urandom_range(0, 3) != 0);
      load_data = WIDTH'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) dir = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) == 0) sat = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 19) == 0) oneshot = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 24) == 0) limit = WIDTH'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) step = ($urandom_range(0, 4) == 0) ? WIDTH'($urandom_range(0, 255)) : WIDTH'($urandom_range(0, 6));
      if ($urandom_range(0, 4) == 0) cmp_val = WIDTH'($urandom_range(0, int'(limit)));
      tick();
      checks++;
      if (count !== mCount[WIDTH-1:0] || tc !== mTc[0]) begin errors++; $display("[TB] FAIL rand_count[%0d] got count=%0d tc=%0b expected %0d %0d", i, count, tc, mCount, mTc); end
      checks++;
      if (busy !== (mState == M_RUN) || done !== (mState == M_DONE)) begin errors++; $display("[TB] FAIL rand_state[%0d] got busy=%0b done=%0b expected state %0d", i, busy, done, mState); end
      checks++;
      if (hit !== (mCount == int'(cmp_val))) begin errors++; $display("[TB] FAIL rand_hit[%0d] got %0b expected %0b", i, hit, (mCount == int'(cmp_val))); end
    end
    applyQuiet();
  endtask

  initial begin
    reset = 1'b1;
    applyQuiet();
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_oneshot();
    test_load_clear();
    test_hit();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_counter.md
Name: prog_counter

Overview:
- Parametrised successor to the team's fixed up/down counter. Adds a programmable upper bound, a programmable step, a choice of wrap or saturate at the bounds, a one-shot run mode driven by a small state machine, and a compare-match output.
- Sits in timer and sequencer datapaths that need bounded counting, terminal-count pulses and a run/done handshake toward a controller.

Parameters:
- WIDTH, 8, width of the count, bound, step, load and compare values.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- clear  input  1  synchronous clear of count and state.
- start  input  1  pulse; moves the block from IDLE or DONE to RUN.
- enable  input  1  advance qualifier; only acts in RUN.
- load  input  1  synchronous load of load_data.
- load_data  input  WIDTH  value to load.
- dir  input  1  0 = count up, 1 = count down.
- step  input  WIDTH  increment or decrement per advance.
- limit  input  WIDTH  inclusive upper bound; the count range is 0..limit.
- sat  input  1  1 = saturate at the bound, 0 = wrap.
- oneshot  input  1  1 = stop in DONE after the first terminal event.
- cmp_val  input  WIDTH  compare value.
- count  output  WIDTH  current count, registered.
- tc  output  1  registered one-cycle terminal-count pulse.
- busy  output  1  high while state is RUN.
- done  output  1  high while state is DONE.
- hit  output  1  (count == cmp_val); decoded from the count register, no added latency.

Behaviour:
- Reset values: count=0, tc=0, state=IDLE, busy=0, done=0.
- State machine (IDLE, RUN, DONE):
  - IDLE -> RUN on start.
  - DONE -> RUN on start; count is not cleared.
  - RUN -> DONE on a terminal event when oneshot=1.
  - RUN stays in RUN on a terminal event when oneshot=0.
  - start while in RUN is ignored.
- Priority each cycle: reset > clear > load > advance.
  - clear: count=0, state=IDLE, tc=0.
  - load: count = min(load_data, limit). The state is unchanged. No advance that cycle. tc=0.
- Advance occurs only when state=RUN, enable=1, and neither clear nor load is active.
- Up advance, computed in WIDTH+1 bits:
  - Terminal event when count+step > limit.
  - Non-terminal: count <= count+step.
  - Terminal: count <= limit if sat=1, else 0.
- Down advance:
  - Terminal event when count < step.
  - Non-terminal: count <= count-step.
  - Terminal: count <= 0 if sat=1, else limit.
- step=0: the count holds and no terminal event occurs, except the case count > limit (below).
- tc: driven to 1 for exactly one cycle on the same edge that applies the terminal update; 0 otherwise. With sat=1 and the count already at the bound, every further advance is a terminal event, so tc pulses on each one.
- Oneshot:
  - The terminal update is applied exactly as defined for sat/wrap.
  - State becomes DONE on the same edge as the tc pulse.
  - In DONE, enable has no effect.
- Changing limit while count > limit: the next advance in either direction is a terminal event. The count is forced to the up-direction terminal value (limit if sat=1, else 0).
- Changing dir, step, sat or limit mid-run takes effect on the next advance. There is no pipelining and the latency is 1 cycle.
- reset asserted mid-run: outputs are cleared immediately (asynchronous); operation restarts from IDLE after deassertion.
- tc is never asserted in the same cycle as load or clear.
- hit follows count combinationally against cmp_val.

Test Plan:
1. WIDTH=8, limit=9, step=1, dir=0, sat=0, oneshot=0; start, then enable for 12 cycles -> count 1..9, 0, 1, 2; tc high only on the edge where 9 -> 0.
2. limit=10, step=4, dir=1, sat=1; load 10, then advance -> count 6, 2, 0 (tc), 0 (tc); count never wraps.
3. oneshot=1, limit=3, step=1, up from 0 -> count 1, 2, 3, 0 with tc; done=1 and busy=0 after that edge; further enable leaves count=0; start returns busy=1.
4. load_data=200 with limit=50 -> count=50. The same cycle with enable=1 gives no advance and tc=0. clear with load gives count=0 and state IDLE.
5. cmp_val=5, counting up from 0 with step=1 -> hit is high exactly while count=5.
6. Assert reset mid-run at count=7 -> count=0, busy=0, tc=0 without waiting for a clock edge; after release, enable without start keeps count=0.
